// File: rtl/fifo_wr_port_arbiter_pkg.sv
// Shared types and helpers for the async FIFO write-port arbiter.
// Pointer width is derived from the address width through ptr_width().
package fifo_wr_port_arbiter_pkg;

  typedef enum logic {ARB, LOCK} wr_arb_state_e;

  function automatic int unsigned ptr_width(input int unsigned asize);
    return asize + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_port_arbiter_if.sv
// Requester and memory-side signals of the write port.
// The arbiter is the slave side; requesters and the read-side synchronizer form the master side.
interface fifo_wr_port_arbiter_if #(
  parameter int NREQ         = 4,
  parameter int DSIZE        = 8,
  parameter int ADDRESS_SIZE = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       grant;
  logic [ADDRESS_SIZE:0] wq2_rptr;
  logic                  winc;
  logic [ADDRESS_SIZE-1:0] waddr;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic [ADDRESS_SIZE:0] wptr;

  modport master (
    output req, lock, req_data, wq2_rptr,
    input  grant, winc, waddr, wdata, wfull, wptr
  );

  modport slave (
    input  req, lock, req_data, wq2_rptr,
    output grant, winc, waddr, wdata, wfull, wptr
  );
endinterface

// File: rtl/fifo_wr_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req scanning upward from last+1 with wrap.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_port_arbiter.sv
// Write-domain arbiter for the async FIFO: round-robin with burst lock,
// owns the binary/Gray write pointer and the registered full flag.
module fifo_wr_port_arbiter
  import fifo_wr_port_arbiter_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DSIZE        = 8,
  parameter int ADDRESS_SIZE = 4
) (
  input logic                   wclk,
  input logic                   wrst,
  fifo_wr_port_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = int'(ptr_width(ADDRESS_SIZE));
  typedef logic [PW-1:0] ptr_t;

  wr_arb_state_e   state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   owner;
  ptr_t            wbin;
  ptr_t            wptr_q;
  logic            wfull_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            winc;
  ptr_t            wbin_next;
  ptr_t            gray_next;
  ptr_t            rptr_full;
  logic [DSIZE-1:0] wdata;

  // During a burst only the owner may be picked; the shared picker then sees one candidate.
  always_comb begin
    elig = bus.req;
    if (state == LOCK) elig = bus.req & (NREQ'(1) << owner);
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (elig),
    .last   (last),
    .enable (!wrst && !wfull_q),
    .grant  (grant),
    .idx    (gidx)
  );

  assign winc      = |grant;
  assign wbin_next = wbin + {{(PW-1){1'b0}}, winc};
  assign gray_next = ptr_t'(bin2gray(32'(wbin_next)));
  // Full when the next write pointer equals the read pointer with the two MSBs inverted.
  assign rptr_full = {~bus.wq2_rptr[ADDRESS_SIZE -: 2], bus.wq2_rptr[ADDRESS_SIZE-2:0]};

  always_comb begin
    wdata = '0;
    if (winc) wdata = bus.req_data[int'(gidx)*DSIZE +: DSIZE];
  end

  assign bus.grant = grant;
  assign bus.winc  = winc;
  assign bus.waddr = wbin[ADDRESS_SIZE-1:0];
  assign bus.wdata = wdata;
  assign bus.wfull = wfull_q;
  assign bus.wptr  = wptr_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state   <= ARB;
      last    <= IW'(NREQ - 1);
      owner   <= '0;
      wbin    <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wptr_q  <= gray_next;
      wfull_q <= (gray_next == rptr_full);
      case (state)
        ARB: begin
          if (winc) begin
            last <= gidx;
            if (bus.lock[gidx]) begin
              state <= LOCK;
              owner <= gidx;
            end
          end
        end
        LOCK: begin
          // Owner withdrawing ends the burst without a grant; wfull alone never does.
          if (!bus.req[owner]) begin
            state <= ARB;
          end else if (winc) begin
            last <= gidx;
            if (!bus.lock[gidx]) state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
